// File: rtl/mpd_pkg.sv
// mpd_pkg: shared types and constants for the project sequencer and heartbeat.
package mpd_pkg;
  typedef enum logic [2:0] {
    S_WAIT_DONE,
    S_IDLE,
    S_DRAIN,
    S_SWITCH,
    S_HOLD,
    S_RUN
  } mpd_seq_state_t;
  localparam int MPD_NUM_PRJ = 4;
  localparam int MPD_SEL_W = 2;
  localparam logic [1:0] MPD_HB_OFF = 2'd0;
  localparam logic [1:0] MPD_HB_RUN = 2'd1;
  localparam logic [1:0] MPD_HB_BUSY = 2'd2;
  // Tap positions counted down from the divider MSB.
  localparam int MPD_HB_RUN_OFS = 1;
  localparam int MPD_HB_BUSY_OFS = 3;
endpackage

// File: rtl/mpd_heartbeat.sv
// mpd_heartbeat: free-running divider whose tap drives the heartbeat LED.
module mpd_heartbeat
  import mpd_pkg::*;
#(
  parameter int HB_W = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] mode,
  output logic       heart_led
);
  logic [HB_W-1:0] cnt;
  always_ff @(posedge clk) cnt <= reset ? '0 : cnt + HB_W'(1);
  assign heart_led = mode == MPD_HB_RUN  ? cnt[HB_W-MPD_HB_RUN_OFS] :
                     mode == MPD_HB_BUSY ? cnt[HB_W-MPD_HB_BUSY_OFS] : 1'b0;
endmodule

// File: rtl/mpd_prj_sequencer.sv
// mpd_prj_sequencer: sequences reset, clock gating and mux switching of the user-project slots.
// Optional watchdog re-reset enabled by defining MPD_PRJ_SEQ_WDOG_EN.
module mpd_prj_sequencer
  import mpd_pkg::*;
#(
  parameter int NUM_PRJ  = MPD_NUM_PRJ,
  parameter int SEL_W    = MPD_SEL_W,
  parameter int SETTLE   = 4,
  parameter int RST_HOLD = 16,
  parameter int HB_W     = 24,
  parameter int WDOG_W   = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fabric_done,
  input  logic               req_valid,
  input  logic [SEL_W-1:0]   req_prj,
  output logic               req_ready,
  output logic               req_err,
  output logic [SEL_W-1:0]   prj_sel,
  output logic [NUM_PRJ-1:0] prj_reset,
  output logic [NUM_PRJ-1:0] prj_clk_en,
  output logic               active,
  output logic               heart_led,
  input  logic               wdog_kick,
  output logic               wdog_trip
);
  localparam int CW = $clog2((SETTLE > RST_HOLD ? SETTLE : RST_HOLD) + 1);
  mpd_seq_state_t state, state_n;
  logic [SEL_W-1:0] target, tgt_n, sel_n;
  logic [CW-1:0] cnt, cnt_n;
  logic from_run, run_n, err_n, bad, wd_fire;
  logic [NUM_PRJ-1:0] sel_oh;
  logic [1:0] hb_mode;
  assign bad = {1'b0, req_prj} >= (SEL_W+1)'(NUM_PRJ);
  assign req_ready = (state == S_IDLE || state == S_RUN) && !req_err;
  assign sel_oh = NUM_PRJ'(1) << prj_sel;
  assign active = state == S_RUN;
  assign prj_reset = active ? ~sel_oh : '1;
  // The outgoing project keeps its clock through DRAIN so it sees its reset edge.
  assign prj_clk_en = (state == S_HOLD || active || (state == S_DRAIN && from_run)) ? sel_oh : '0;
  assign hb_mode = state == S_WAIT_DONE ? MPD_HB_OFF : active ? MPD_HB_RUN : MPD_HB_BUSY;
  always_comb begin
    state_n = state;
    tgt_n = target;
    sel_n = prj_sel;
    run_n = from_run;
    err_n = 1'b0;
    cnt_n = cnt - CW'(cnt != '0);
    if (!fabric_done) state_n = S_WAIT_DONE;
    else
      unique case (state)
        S_WAIT_DONE: state_n = S_IDLE;
        S_IDLE, S_RUN:
          if (wd_fire) begin
            state_n = S_DRAIN;
            tgt_n = prj_sel;
            run_n = 1'b1;
          end else if (req_valid && req_ready) begin
            err_n = bad;
            if (!bad) begin
              state_n = S_DRAIN;
              tgt_n = req_prj;
              run_n = state == S_RUN;
            end
          end
        S_DRAIN: begin
          state_n = S_SWITCH;
          sel_n = target;
          cnt_n = CW'(SETTLE - 1);
        end
        S_SWITCH:
          if (cnt == '0) begin
            state_n = S_HOLD;
            cnt_n = CW'(RST_HOLD);
          end
        // RST_HOLD+1 cycles in HOLD gives RST_HOLD clocked edges once the gate opens.
        S_HOLD: state_n = cnt == '0 ? S_RUN : S_HOLD;
        default: state_n = S_WAIT_DONE;
      endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_WAIT_DONE;
      prj_sel <= '0;
      target <= '0;
      from_run <= 1'b0;
      cnt <= '0;
      req_err <= 1'b0;
    end else begin
      state <= state_n;
      prj_sel <= sel_n;
      target <= tgt_n;
      from_run <= run_n;
      cnt <= cnt_n;
      req_err <= err_n;
    end
  end
`ifdef MPD_PRJ_SEQ_WDOG_EN
  logic [WDOG_W-1:0] wdog_cnt;
  assign wd_fire = state == S_RUN && &wdog_cnt;
  always_ff @(posedge clk) begin
    wdog_cnt <= (reset || state != S_RUN || wdog_kick || wd_fire) ? '0 : wdog_cnt + WDOG_W'(1);
    wdog_trip <= !reset && fabric_done && wd_fire;
  end
`else
  logic unused_wdog;
  assign unused_wdog = wdog_kick | (WDOG_W == 0);
  assign wd_fire = 1'b0;
  assign wdog_trip = 1'b0;
`endif
  mpd_heartbeat #(.HB_W(HB_W)) u_hb (
    .clk(clk),
    .reset(reset),
    .mode(hb_mode),
    .heart_led(heart_led)
  );
endmodule

// File: tb/tb_mpd_prj_sequencer.sv
// tb_mpd_prj_sequencer: timeline model of the switch sequence plus directed checks.
module tb_mpd_prj_sequencer;
  localparam int S = 4, R = 16, RUN_AT = S + R + 2, WDW = 6, NP = 4;
  logic clk = 1'b0;
  logic reset, fabric_done, req_valid, wdog_kick, r3_valid;
  logic [1:0] req_prj, r3_prj, prj_sel, sel3;
  logic req_ready, req_err, active, heart_led, wdog_trip;
  logic ready3, err3, active3, hb3, trip3;
  logic [3:0] prj_reset, prj_clk_en;
  logic [2:0] prj_reset3, clk3;
  int checks = 0, errors = 0, trips, k;
  always #5 clk = ~clk;

  mpd_prj_sequencer #(.NUM_PRJ(4), .SEL_W(2), .SETTLE(S), .RST_HOLD(R), .HB_W(6), .WDOG_W(WDW)) dut (
    .clk(clk), .reset(reset), .fabric_done(fabric_done), .req_valid(req_valid), .req_prj(req_prj),
    .req_ready(req_ready), .req_err(req_err), .prj_sel(prj_sel), .prj_reset(prj_reset),
    .prj_clk_en(prj_clk_en), .active(active), .heart_led(heart_led), .wdog_kick(wdog_kick),
    .wdog_trip(wdog_trip));

  mpd_prj_sequencer #(.NUM_PRJ(3), .SEL_W(2), .SETTLE(S), .RST_HOLD(R), .HB_W(6), .WDOG_W(WDW)) dut3 (
    .clk(clk), .reset(reset), .fabric_done(fabric_done), .req_valid(r3_valid), .req_prj(r3_prj),
    .req_ready(ready3), .req_err(err3), .prj_sel(sel3), .prj_reset(prj_reset3),
    .prj_clk_en(clk3), .active(active3), .heart_led(hb3), .wdog_kick(wdog_kick),
    .wdog_trip(trip3));

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Model: m_n counts edges since the accepting edge (-1 = no sequence in flight).
  bit m_valid = 1'b0, m_cfg, m_err, m_trip, m_rdy, m_run, m_fire;
  int m_n, m_sel, m_tgt, m_prev, m_hb, m_wd;
  logic e_act;
  logic [3:0] e_clk;

  function automatic bit m_ready();
    return m_cfg && (m_n < 0 || m_n == RUN_AT) && !m_err;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_cfg = 1'b0; m_n = -1; m_sel = 0; m_tgt = 0; m_prev = -1;
      m_err = 1'b0; m_trip = 1'b0; m_hb = 0; m_wd = 0;
    end else begin
      m_rdy = m_ready();
      m_run = m_cfg && m_n == RUN_AT;
      m_fire = 1'b0;
`ifdef MPD_PRJ_SEQ_WDOG_EN
      m_fire = m_run && m_wd == (1 << WDW) - 1;
      m_wd = (!m_run || wdog_kick || m_fire) ? 0 : m_wd + 1;
`endif
      m_hb++;
      m_err = 1'b0;
      m_trip = 1'b0;
      if (!fabric_done) begin
        m_cfg = 1'b0; m_n = -1;
      end else if (!m_cfg) m_cfg = 1'b1;
      else if (m_fire) begin
        m_trip = 1'b1; m_prev = m_sel; m_tgt = m_sel; m_n = 0;
      end else if (m_n >= 0 && m_n < RUN_AT) begin
        m_n++;
        if (m_n == 1) m_sel = m_tgt;
      end else if (m_rdy && req_valid) begin
        if (int'(req_prj) >= NP) m_err = 1'b1;
        else begin
          m_prev = m_run ? m_sel : -1; m_tgt = int'(req_prj); m_n = 0;
        end
      end
    end
    m_valid = 1'b1;
  end

  always @(negedge clk) if (m_valid) begin
    e_act = m_cfg && m_n == RUN_AT;
    e_clk = m_n == 0 ? (m_prev >= 0 ? 4'b1 << m_prev : 4'b0) :
            (m_n >= S + 1) ? 4'b1 << m_sel : 4'b0;
    chk("active", active, e_act);
    chk("prj_sel", prj_sel, m_sel);
    chk("prj_reset", prj_reset, e_act ? 4'hF & ~(4'b1 << m_sel) : 4'hF);
    chk("prj_clk_en", prj_clk_en, e_clk);
    chk("req_ready", req_ready, m_ready());
    chk("req_err", req_err, m_err);
    chk("heart_led", heart_led, !m_cfg ? 0 : e_act ? (m_hb >> 5) & 1 : (m_hb >> 3) & 1);
    chk("wdog_trip", wdog_trip, m_trip);
  end

  initial begin
    reset = 1'b1; fabric_done = 1'b0; req_valid = 1'b0; req_prj = '0;
    r3_valid = 1'b0; r3_prj = '0; wdog_kick = 1'b0;
    repeat (3) cyc();
    reset = 1'b0;
    repeat (50) cyc();
    chk("t1_rst", prj_reset, 4'hF);
    chk("t1_clk", prj_clk_en, 0);
    chk("t1_rdy", req_ready, 0);
    chk("t1_hb", heart_led, 0);
    fabric_done = 1'b1;
    cyc();
    chk("idle_rdy", req_ready, 1);
    req_valid = 1'b1; req_prj = 2; r3_valid = 1'b1; r3_prj = 1;
    cyc();
    req_valid = 1'b0; r3_valid = 1'b0;
    chk("t2_e0_rdy", req_ready, 0);
    cyc();
    chk("t2_e1_sel", prj_sel, 2);
    chk("t2_e1_gate", prj_clk_en, 0);
    repeat (4) cyc();
    chk("t2_e5_clk", prj_clk_en, 4'b0100);
    chk("t2_e5_rst", prj_reset, 4'hF);
    repeat (16) cyc();
    chk("t2_e21_act", active, 0);
    cyc();
    chk("t2_e22_act", active, 1);
    chk("t2_e22_rst", prj_reset, 4'b1011);
    chk("t5_act3", active3, 1);
    chk("t5_rst3", prj_reset3, 3'b101);
    repeat (40) cyc();
    r3_valid = 1'b1; r3_prj = 3;
    cyc();
    r3_valid = 1'b0;
    chk("t5_err3", err3, 1);
    chk("t5_act3_kept", active3, 1);
    chk("t5_sel3_kept", sel3, 1);
    chk("t5_rdy3_low", ready3, 0);
    cyc();
    chk("t5_err3_pulse", err3, 0);
    chk("t5_rdy3_back", ready3, 1);
    req_valid = 1'b1; req_prj = 0;
    cyc();
    req_valid = 1'b0;
    chk("t3_drain_rst", prj_reset, 4'hF);
    chk("t3_drain_clk", prj_clk_en, 4'b0100);
    cyc();
    chk("t3_e1_clk", prj_clk_en, 0);
    chk("t3_e1_sel", prj_sel, 0);
    repeat (20) cyc();
    chk("t3_e21_act", active, 0);
    cyc();
    chk("t3_e22_act", active, 1);
    chk("t3_e22_rst", prj_reset, 4'b1110);
    req_valid = 1'b1; req_prj = 0;
    repeat (30) cyc();
    req_valid = 1'b0;
    repeat (25) cyc();
    chk("soft_rst_act", active, 1);
    req_valid = 1'b1; req_prj = 3;
    cyc();
    req_valid = 1'b0;
    repeat (10) cyc();
    fabric_done = 1'b0;
    cyc();
    chk("t4_act", active, 0);
    chk("t4_rst", prj_reset, 4'hF);
    chk("t4_clk", prj_clk_en, 0);
    chk("t4_sel_kept", prj_sel, 3);
    chk("t4_rdy", req_ready, 0);
    repeat (5) cyc();
    fabric_done = 1'b1;
    cyc();
    req_valid = 1'b1; req_prj = 1;
    cyc();
    req_valid = 1'b0;
    repeat (21) cyc();
    chk("t4_e21_act", active, 0);
    cyc();
    chk("t4_e22_act", active, 1);
    chk("t4_e22_rst", prj_reset, 4'b1101);
    req_valid = 1'b1; req_prj = 2; fabric_done = 1'b0;
    cyc();
    req_valid = 1'b0;
    chk("drop_act", active, 0);
    chk("drop_sel", prj_sel, 1);
    fabric_done = 1'b1;
    repeat (3) cyc();
    chk("drop_idle_rdy", req_ready, 1);
    chk("drop_idle_act", active, 0);
`ifdef MPD_PRJ_SEQ_WDOG_EN
    req_valid = 1'b1; req_prj = 0;
    cyc();
    req_valid = 1'b0;
    repeat (22) cyc();
    chk("t6_run", active, 1);
    k = 0;
    while (!wdog_trip && k < 100) begin
      cyc();
      k++;
    end
    chk("t6_trip_seen", wdog_trip, 1);
    chk("t6_trip_act", active, 0);
    repeat (22) cyc();
    chk("t6_rerun", active, 1);
    trips = 0;
    for (int i = 0; i < 150; i++) begin
      wdog_kick = (i % 10) == 0;
      cyc();
      if (wdog_trip) trips++;
    end
    wdog_kick = 1'b0;
    chk("t6_kicked_trips", trips, 0);
`endif
    repeat (2) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
